serial_tx_ctrl: RTL

//  Sequencing controller placed directly upstream of the 4-bit universal shift register.
//  - Accepts a parallel word over a valid/ready handshake.
//  - Drives the register's mode selects (s1,s0), parallel input and serial fill inputs
//    so the word is loaded and then shifted out one bit per clock.
//  - Presents each bit with a valid/stall handshake and pulses done at end of word.
//  - Observes the register contents via its A_par output; holds no data copy beyond the input latch.

---
 rtl/serial_tx_ctrl_if.sv | 30 +++
 rtl/serial_tx_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/serial_tx_ctrl_if.sv
// Handshake and shift-register control bundle between serial_tx_ctrl and its peers.
// master = controller side; slave = word producer, bit consumer and shift register side.
interface serial_tx_ctrl_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] data_in;
   logic             data_valid;
   logic             data_ready;
   logic             lsb_first;
   logic [WIDTH-1:0] A_par;
   logic [WIDTH-1:0] I_par;
   logic             s1;
   logic             s0;
   logic             MSB_in;
   logic             LSB_in;
   logic             ser_out;
   logic             ser_valid;
   logic             ser_stall;
   logic             done;

   modport master (
      input  data_in, data_valid, lsb_first, A_par, ser_stall,
      output data_ready, I_par, s1, s0, MSB_in, LSB_in, ser_out, ser_valid, done
   );

   modport slave (
      output data_in, data_valid, lsb_first, A_par, ser_stall,
      input  data_ready, I_par, s1, s0, MSB_in, LSB_in, ser_out, ser_valid, done
   );
endinterface

// File: rtl/serial_tx_ctrl.sv
// Sequences a 4-bit universal shift register: load a word, shift it out a bit per clock.
// Latency: handshake -> LOAD 1 cycle -> WIDTH bit cycles (+1 per stall) -> done pulse.
// Backpressure: ser_stall holds the register (mode 00); data_ready is high only in IDLE.
module serial_tx_ctrl #(
   parameter int   WIDTH = 4,
   parameter logic FILL  = 1'b0
) (
   input  logic             CLK,
   input  logic             Clear,
   serial_tx_ctrl_if.master bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;
   logic [WIDTH-1:0] data_q;
   logic             dir_q;

   logic [1:0]       mode;
   logic [WIDTH-1:0] ipar;
   logic             ready;
   logic             sv;
   logic             so;
   logic             dn;

   always_ff @(posedge CLK or posedge Clear) begin
      if (Clear) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
         dir_q  <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         // Only IDLE captures a word; data_valid elsewhere is ignored, not queued.
         if (state == IDLE && bus.data_valid) begin
            data_q <= bus.data_in;
            dir_q  <= bus.lsb_first;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      mode      = 2'b00;
      ipar      = '0;
      ready     = 1'b0;
      sv        = 1'b0;
      so        = 1'b0;
      dn        = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.data_valid) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            mode      = 2'b11;
            ipar      = data_q;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            sv = 1'b1;
            // The bit on the wire is whatever sits at the exit end of the register.
            so = dir_q ? bus.A_par[0] : bus.A_par[WIDTH-1];
            if (!bus.ser_stall) begin
               mode = dir_q ? 2'b01 : 2'b10;
               if (cnt == LAST) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
         end
         DONE: begin
            dn        = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign bus.data_ready = ready;
   assign bus.s1         = mode[1];
   assign bus.s0         = mode[0];
   assign bus.I_par      = ipar;
   assign bus.MSB_in     = FILL;
   assign bus.LSB_in     = FILL;
   assign bus.ser_out    = so;
   assign bus.ser_valid  = sv;
   assign bus.done       = dn;
endmodule
